// File: rtl/point_drive_pkg.sv
// Shared types for the point-motor drive slice: channel state and position encoding.
package point_drive_pkg;

    typedef enum logic [1:0] {
        DEAD  = 2'd0,
        DRIVE = 2'd1,
        HELD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic POS_NOR = 1'b0;
    localparam logic POS_REV = 1'b1;

endpackage

// File: rtl/point_channel.sv
// One point channel: contact synchronizer, throw/hold/fault FSM, shared cycle counter
// and registered motor/status outputs decoded from the next state.
module point_channel
    import point_drive_pkg::*;
#(
    parameter int unsigned DEAD_CYC    = 50_000,
    parameter int unsigned TIMEOUT_CYC = 150_000_000
) (
    input  logic clk,
    input  logic rest_n,
    input  logic sw_cmd,
    input  logic det_nor,
    input  logic det_rev,
    input  logic fault_clr,
    output logic mot_nor,
    output logic mot_rev,
    output logic locked,
    output logic pos,
    output logic fault
);

    localparam int unsigned      CNT_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       nor_sync, rev_sync;
    logic             dn, dr;
    state_t           state, state_n;
    logic             target, target_n;
    logic             pos_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             cmd_chg, at_tgt, both;

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            nor_sync <= '0;
            rev_sync <= '0;
        end else begin
            nor_sync <= {nor_sync[0], det_nor};
            rev_sync <= {rev_sync[0], det_rev};
        end
    end

    assign dn = nor_sync[1];
    assign dr = rev_sync[1];

    always_comb begin
        state_n  = state;
        target_n = target;
        cnt_n    = cnt;
        pos_n    = pos;
        cmd_chg  = (sw_cmd != target);
        both     = dn & dr;
        // Confirmation needs the target contact made and the opposite one open.
        at_tgt   = (target == POS_REV) ? (dr & ~dn) : (dn & ~dr);
        unique case (state)
            DEAD: begin
                if (cmd_chg) begin
                    target_n = sw_cmd;
                    cnt_n    = '0;
                end else if (cnt == DEAD_LAST) begin
                    state_n = DRIVE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DRIVE: begin
                if (both) begin
                    state_n = FAULT;
                    cnt_n   = '0;
                end else if (cmd_chg) begin
                    target_n = sw_cmd;
                    state_n  = DEAD;
                    cnt_n    = '0;
                end else if (at_tgt) begin
                    state_n = HELD;
                    pos_n   = target;
                    cnt_n   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_n = FAULT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (both) begin
                    state_n = FAULT;
                end else if (cmd_chg) begin
                    target_n = sw_cmd;
                    state_n  = DEAD;
                    cnt_n    = '0;
                end else if (!at_tgt) begin
                    state_n = FAULT;
                end
            end
            FAULT: begin
                if (fault_clr && !both) begin
                    target_n = sw_cmd;
                    state_n  = DEAD;
                    cnt_n    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            state   <= DEAD;
            target  <= POS_NOR;
            cnt     <= '0;
            pos     <= POS_NOR;
            mot_nor <= 1'b0;
            mot_rev <= 1'b0;
            locked  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_n;
            target  <= target_n;
            cnt     <= cnt_n;
            pos     <= pos_n;
            mot_nor <= (state_n == DRIVE) && (target_n == POS_NOR);
            mot_rev <= (state_n == DRIVE) && (target_n == POS_REV);
            locked  <= (state_n == HELD);
            fault   <= (state_n == FAULT);
        end
    end

endmodule

// File: rtl/point_drive.sv
// Two independent point channels plus the registered route-ready flag
// reported to the signalling logic.
module point_drive
    import point_drive_pkg::*;
#(
    parameter int unsigned DEAD_CYC    = 50_000,
    parameter int unsigned TIMEOUT_CYC = 150_000_000
) (
    input  logic       clk,
    input  logic       rest_n,
    input  logic [1:0] sw_cmd,
    input  logic [1:0] det_nor,
    input  logic [1:0] det_rev,
    input  logic [1:0] fault_clr,
    output logic [1:0] mot_nor,
    output logic [1:0] mot_rev,
    output logic [1:0] locked,
    output logic [1:0] pos,
    output logic [1:0] fault,
    output logic       route_ok
);

    for (genvar i = 0; i < 2; i++) begin : g_ch
        point_channel #(
            .DEAD_CYC    (DEAD_CYC),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_ch (
            .clk       (clk),
            .rest_n    (rest_n),
            .sw_cmd    (sw_cmd[i]),
            .det_nor   (det_nor[i]),
            .det_rev   (det_rev[i]),
            .fault_clr (fault_clr[i]),
            .mot_nor   (mot_nor[i]),
            .mot_rev   (mot_rev[i]),
            .locked    (locked[i]),
            .pos       (pos[i]),
            .fault     (fault[i])
        );
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) route_ok <= 1'b0;
        else         route_ok <= (&locked) & ~(|fault);
    end

endmodule

// File: tb/tb_point_drive.sv
// Directed scenarios followed by random commands, field faults and clears, each cycle
// compared against an event-level reference model driven by a simple point-field plant.
module tb_point_drive;

    localparam int unsigned DEAD = 4;
    localparam int unsigned TMO  = 20;

    logic       clk = 1'b0;
    logic       rest_n;
    logic [1:0] sw_cmd, det_nor, det_rev, fault_clr;
    logic [1:0] mot_nor, mot_rev, locked, pos, fault;
    logic       route_ok;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // reference model: dead time counts down, drive age counts up, flags for held/fault
    bit          m_tgt [2];
    bit          m_pos [2];
    bit          m_fault [2];
    bit          m_held [2];
    int unsigned m_dead [2];
    int unsigned m_age [2];
    bit          m_route;
    logic [1:0]  q_nor [$];
    logic [1:0]  q_rev [$];

    // field plant: contact for a side closes after f_n cycles of drive toward it
    bit          f_at [2];
    bit          f_pos [2];
    bit          f_dir [2];
    bit          f_stuck [2];
    int unsigned f_cnt [2];
    int unsigned f_n [2];

    always #5 clk = ~clk;

    point_drive #(
        .DEAD_CYC    (DEAD),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rest_n    (rest_n),
        .sw_cmd    (sw_cmd),
        .det_nor   (det_nor),
        .det_rev   (det_rev),
        .fault_clr (fault_clr),
        .mot_nor   (mot_nor),
        .mot_rev   (mot_rev),
        .locked    (locked),
        .pos       (pos),
        .fault     (fault),
        .route_ok  (route_ok)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int unsigned c = 0; c < 2; c++) begin
            m_tgt[c]   = 1'b0;
            m_pos[c]   = 1'b0;
            m_fault[c] = 1'b0;
            m_held[c]  = 1'b0;
            m_dead[c]  = DEAD;
            m_age[c]   = 0;
        end
        m_route = 1'b0;
        q_nor = '{2'b00, 2'b00};
        q_rev = '{2'b00, 2'b00};
    endtask

    task automatic model_edge(input logic [1:0] cmd, input logic [1:0] clr,
                              input logic [1:0] pn, input logic [1:0] pr);
        logic [1:0] dn, dr;
        bit n, r, ok;
        dn = q_nor.pop_front();
        dr = q_rev.pop_front();
        q_nor.push_back(pn);
        q_rev.push_back(pr);
        m_route = m_held[0] && m_held[1] && !m_fault[0] && !m_fault[1];
        for (int unsigned c = 0; c < 2; c++) begin
            n  = dn[c];
            r  = dr[c];
            ok = m_tgt[c] ? (r && !n) : (n && !r);
            if (m_fault[c]) begin
                if (clr[c] && !(n && r)) begin
                    m_fault[c] = 1'b0;
                    m_tgt[c]   = cmd[c];
                    m_dead[c]  = DEAD;
                end
            end else if (m_held[c]) begin
                if (n && r) begin
                    m_held[c] = 1'b0; m_fault[c] = 1'b1;
                end else if (cmd[c] != m_tgt[c]) begin
                    m_held[c] = 1'b0; m_tgt[c] = cmd[c]; m_dead[c] = DEAD;
                end else if (!ok) begin
                    m_held[c] = 1'b0; m_fault[c] = 1'b1;
                end
            end else if (m_dead[c] > 0) begin
                if (cmd[c] != m_tgt[c]) begin
                    m_tgt[c] = cmd[c]; m_dead[c] = DEAD;
                end else begin
                    m_dead[c]--;
                    if (m_dead[c] == 0) m_age[c] = 0;
                end
            end else begin
                if (n && r)                      m_fault[c] = 1'b1;
                else if (cmd[c] != m_tgt[c]) begin
                    m_tgt[c] = cmd[c]; m_dead[c] = DEAD;
                end else if (ok) begin
                    m_held[c] = 1'b1; m_pos[c] = m_tgt[c];
                end else if (m_age[c] == TMO - 1) m_fault[c] = 1'b1;
                else                             m_age[c]++;
            end
        end
    endtask

    task automatic check_all();
        logic [1:0] en, er, el, ep, ef;
        for (int unsigned c = 0; c < 2; c++) begin
            en[c] = !m_fault[c] && !m_held[c] && m_dead[c] == 0 && !m_tgt[c];
            er[c] = !m_fault[c] && !m_held[c] && m_dead[c] == 0 &&  m_tgt[c];
            el[c] = m_held[c];
            ep[c] = m_pos[c];
            ef[c] = m_fault[c];
        end
        chk("mot_nor",  32'(mot_nor), 32'(en));
        chk("mot_rev",  32'(mot_rev), 32'(er));
        chk("mot_excl", 32'(mot_nor & mot_rev), 32'(0));
        chk("locked",   32'(locked), 32'(el));
        chk("pos",      32'(pos), 32'(ep));
        chk("fault",    32'(fault), 32'(ef));
        chk("route_ok", 32'(route_ok), 32'(m_route));
    endtask

    task automatic field_update();
        bit d;
        for (int unsigned c = 0; c < 2; c++) begin
            if (mot_nor[c] || mot_rev[c]) begin
                d = mot_rev[c];
                if (d != f_dir[c]) begin
                    f_dir[c] = d;
                    f_cnt[c] = 0;
                end
                if (!(f_at[c] && f_pos[c] == d)) begin
                    f_at[c] = 1'b0;
                    f_cnt[c]++;
                    if (!f_stuck[c] && f_cnt[c] >= f_n[c]) begin
                        f_at[c]  = 1'b1;
                        f_pos[c] = d;
                        f_cnt[c] = 0;
                    end
                end
            end
            det_nor[c] = f_at[c] && !f_pos[c];
            det_rev[c] = f_at[c] &&  f_pos[c];
        end
    endtask

    task automatic step();
        logic [1:0] c, fc, pn, pr;
        c  = sw_cmd;
        fc = fault_clr;
        pn = det_nor;
        pr = det_rev;
        @(posedge clk);
        model_edge(c, fc, pn, pr);
        #1;
        check_all();
        field_update();
    endtask

    initial begin
        int unsigned rise, fault_at, r;
        rest_n    = 1'b0;
        sw_cmd    = 2'b00;
        fault_clr = 2'b00;
        for (int unsigned c = 0; c < 2; c++) begin
            f_at[c] = 1'b1; f_pos[c] = 1'b0; f_dir[c] = 1'b0;
            f_stuck[c] = 1'b0; f_cnt[c] = 0; f_n[c] = 5;
        end
        det_nor = 2'b11;
        det_rev = 2'b00;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #2 rest_n = 1'b1;

        // 1: release with field at normal
        repeat (3) step();
        chk("t1_dead_off", 32'(mot_nor), 32'(0));
        step();
        chk("t1_drive_on", 32'(mot_nor), 32'(2'b11));
        repeat (6) step();
        chk("t1_locked", 32'(locked), 32'(2'b11));
        chk("t1_pos", 32'(pos), 32'(0));
        chk("t1_route", 32'(route_ok), 32'(1));

        // 2: throw ch0 to reverse
        sw_cmd[0] = 1'b1;
        step();
        chk("t2_unlock", 32'(locked[0]), 32'(0));
        rise = 0;
        for (int unsigned i = 1; i <= 30; i++) begin
            step();
            if (rise == 0 && mot_rev[0]) rise = i;
        end
        chk("t2_dead_gap", rise, DEAD);
        chk("t2_pos", 32'(pos[0]), 32'(1));
        chk("t2_locked", 32'(locked[0]), 32'(1));

        // 3: reversal mid-drive
        sw_cmd[0] = 1'b0;
        repeat (30) step();
        sw_cmd[0] = 1'b1;
        repeat (6) step();
        chk("t3_driving", 32'(mot_rev[0]), 32'(1));
        sw_cmd[0] = 1'b0;
        step();
        chk("t3_cut", 32'({mot_nor[0], mot_rev[0]}), 32'(0));
        for (int unsigned i = 0; i < DEAD - 1; i++) begin
            step();
            chk("t3_dead_off", 32'({mot_nor[0], mot_rev[0]}), 32'(0));
        end
        step();
        chk("t3_nor_on", 32'(mot_nor[0]), 32'(1));
        repeat (20) step();

        // 4: field never confirms
        f_stuck[0] = 1'b1;
        sw_cmd[0]  = 1'b1;
        fault_at = 0;
        for (int unsigned i = 1; i <= 30; i++) begin
            step();
            if (fault_at == 0 && fault[0]) fault_at = i;
        end
        chk("t4_fault_time", fault_at, 1 + DEAD + TMO);
        chk("t4_mot_off", 32'({mot_nor[0], mot_rev[0]}), 32'(0));
        chk("t4_route", 32'(route_ok), 32'(0));
        sw_cmd[0] = 1'b0;
        repeat (3) step();
        chk("t4_ignore_cmd", 32'(fault[0]), 32'(1));
        f_stuck[0]   = 1'b0;
        sw_cmd[0]    = 1'b1;
        fault_clr[0] = 1'b1;
        step();
        fault_clr[0] = 1'b0;
        chk("t4_cleared", 32'(fault[0]), 32'(0));
        repeat (30) step();
        chk("t4_retry_lock", 32'({locked[0], pos[0]}), 32'(2'b11));

        // 5: one-cycle glitch on ch1 normal contact
        det_nor[1] = 1'b0;
        repeat (2) step();
        chk("t5_not_yet", 32'(fault[1]), 32'(0));
        step();
        chk("t5_fault", 32'(fault[1]), 32'(1));
        chk("t5_ch0_ok", 32'({fault[0], locked[0]}), 32'(2'b01));
        fault_clr[1] = 1'b1;
        step();
        fault_clr[1] = 1'b0;
        repeat (20) step();

        // 6: reset mid-drive
        sw_cmd[0] = 1'b0;
        repeat (6) step();
        chk("t6_driving", 32'(mot_nor[0]), 32'(1));
        #3 rest_n = 1'b0;
        sw_cmd = 2'b00;
        model_reset();
        #1;
        chk("t6_async", 32'({mot_nor, mot_rev, locked, pos, fault, route_ok}), 32'(0));
        check_all();
        @(posedge clk);
        @(posedge clk);
        #2 rest_n = 1'b1;
        repeat (30) step();
        chk("t6_rethrow", 32'({locked, pos}), 32'(4'b1100));

        // random commands, clears, stuck fields, glitches and contradictory contacts
        for (int unsigned i = 0; i < 1500; i++) begin
            fault_clr = 2'b00;
            if ($urandom_range(0, 24) == 0) begin
                r = $urandom_range(0, 1);
                sw_cmd[r] = ~sw_cmd[r];
                f_n[r]    = $urandom_range(1, 8);
            end
            if ($urandom_range(0, 15) == 0) fault_clr[$urandom_range(0, 1)] = 1'b1;
            if ($urandom_range(0, 99) == 0) begin
                r = $urandom_range(0, 1);
                f_stuck[r] = !f_stuck[r];
            end
            if ($urandom_range(0, 149) == 0) begin
                r = $urandom_range(0, 1);
                det_nor[r] = ~det_nor[r];
            end
            if ($urandom_range(0, 199) == 0) begin
                r = $urandom_range(0, 1);
                det_nor[r] = 1'b1;
                det_rev[r] = 1'b1;
            end
            step();
        end
        fault_clr = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
